// File: rtl/mux_scan_pkg.sv
// Shared types and helpers for the 4:1 mux scan controller.
package mux_scan_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_PRESENT = 2'd2
  } state_t;

  // Result of a channel search: found=0 means no channel qualified.
  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] ch;
  } ch_pick_t;

  // Lowest enabled channel strictly above cur.
  function automatic ch_pick_t next_enabled(input logic [NUM_CH-1:0] mask,
                                            input logic [SEL_W-1:0]  cur);
    ch_pick_t pick;
    pick = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'(cur))) begin
        pick.found = 1'b1;
        pick.ch    = SEL_W'(i);
      end
    end
    return pick;
  endfunction

  // Lowest enabled channel overall, used when a scan begins.
  function automatic ch_pick_t first_enabled(input logic [NUM_CH-1:0] mask);
    ch_pick_t pick;
    if (mask[0]) begin
      pick.found = 1'b1;
      pick.ch    = '0;
    end else begin
      pick = next_enabled(mask, '0);
    end
    return pick;
  endfunction

endpackage

// File: rtl/mux_scan_ctrl_dwell_cnt.sv
// Loadable settle down-counter; zero flags the end of a channel's dwell.
module scan_dwell_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;

  // Load wins over decrement so a new dwell always starts from the full value.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan controller: steps the 4:1 mux select over enabled channels, samples
// each after its settle time and presents the frame on valid/ready.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       start_in,
  input  logic       continuous_in,
  input  logic       clear_in,
  input  logic [3:0] en_mask_in,
  input  logic       mux_q_in,
  output logic [1:0] sel_out,
  output logic       busy_out,
  output logic [3:0] frame_out,
  output logic       frame_valid_out,
  input  logic       frame_ready_in
);

  state_t            state_q, state_nxt;
  logic [NUM_CH-1:0] mask_q, shadow_q, shadow_d, frame_q;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              frame_valid_q;
  logic              start_scan, cnt_load, cnt_dec, cnt_zero;
  logic              present_load, valid_clr;
  ch_pick_t          nxt_pick, first_pick;

  scan_dwell_cnt #(.CNT_W(CNT_W)) u_dwell (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (CNT_W'(SETTLE_CYCLES)),
    .zero     (cnt_zero)
  );

  // Next-state, next select and shadow frame; clear overrides everything at the end.
  // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt    = state_q;
    sel_d        = sel_q;
    shadow_d     = shadow_q;
    start_scan   = 1'b0;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    present_load = 1'b0;
    valid_clr    = 1'b0;
    nxt_pick     = next_enabled(mask_q, sel_q);
    first_pick   = first_enabled(en_mask_in);

    unique case (state_q)
      ST_IDLE: start_scan = start_in;
      ST_SETTLE: begin
        if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else begin
          shadow_d = shadow_q | (NUM_CH'(mux_q_in) << sel_q);
          if (nxt_pick.found) begin
            sel_d    = nxt_pick.ch;
            cnt_load = 1'b1;
          end else begin
            state_nxt    = ST_PRESENT;
            present_load = 1'b1;
          end
        end
      end
      ST_PRESENT: begin
        if (frame_valid_q && frame_ready_in) begin
          valid_clr = 1'b1;
          if (continuous_in) start_scan = 1'b1;
          else               state_nxt  = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // A new scan (from IDLE or a continuous restart) clears the shadow frame.
    if (start_scan) begin
      shadow_d = '0;
      if (first_pick.found) begin
        sel_d     = first_pick.ch;
        cnt_load  = 1'b1;
        state_nxt = ST_SETTLE;
      end else begin
        state_nxt    = ST_PRESENT;
        present_load = 1'b1;
      end
    end

    // Abort keeps frame and select, only drops the scan and the valid flag.
    if (clear_in) begin
      state_nxt    = ST_IDLE;
      sel_d        = sel_q;
      shadow_d     = shadow_q;
      start_scan   = 1'b0;
      cnt_load     = 1'b0;
      cnt_dec      = 1'b0;
      present_load = 1'b0;
      valid_clr    = 1'b1;
    end
  end

  // State, select, mask, shadow and output registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q       <= ST_IDLE;
      sel_q         <= '0;
      mask_q        <= '0;
      shadow_q      <= '0;
      frame_q       <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      sel_q    <= sel_d;
      shadow_q <= shadow_d;
      if (start_scan)   mask_q  <= en_mask_in;
      if (present_load) frame_q <= shadow_d;
      if (present_load)   frame_valid_q <= 1'b1;
      else if (valid_clr) frame_valid_q <= 1'b0;
    end
  end

  assign sel_out         = sel_q;
  assign busy_out        = (state_q == ST_SETTLE);
  assign frame_out       = frame_q;
  assign frame_valid_out = frame_valid_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: one DUT with SETTLE_CYCLES=2, one with 0.
module tb_mux_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, cont, clear, ready;
  logic [3:0] mask, d;
  logic [1:0] sel, sel0;
  logic       busy, busy0, valid, valid0, mux_q, mux_q0;
  logic [3:0] frame, frame0;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  // Behavioural 4:1 mux: channel k carries d[k].
  assign mux_q  = d[sel];
  assign mux_q0 = d[sel0];

  mux_scan_ctrl #(.SETTLE_CYCLES(2), .CNT_W(8)) dut (
    .clk_in(clk), .rst_in(rst), .start_in(start), .continuous_in(cont),
    .clear_in(clear), .en_mask_in(mask), .mux_q_in(mux_q), .sel_out(sel),
    .busy_out(busy), .frame_out(frame), .frame_valid_out(valid),
    .frame_ready_in(ready)
  );

  mux_scan_ctrl #(.SETTLE_CYCLES(0), .CNT_W(8)) dut0 (
    .clk_in(clk), .rst_in(rst), .start_in(start), .continuous_in(cont),
    .clear_in(clear), .en_mask_in(mask), .mux_q_in(mux_q0), .sel_out(sel0),
    .busy_out(busy0), .frame_out(frame0), .frame_valid_out(valid0),
    .frame_ready_in(ready)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (sel !== 2'd0)   begin errors++; $display("FAIL reset_sel: got %0d expected 0", sel); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (frame !== 4'h0) begin errors++; $display("FAIL reset_frame: got %h expected 0", frame); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", valid); end
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic test_scan();
    d = 4'b1010; mask = 4'b1111; ready = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (sel !== 2'd0 || busy !== 1'b1) begin errors++; $display("FAIL scan_start: sel %0d busy %0b expected 0 1", sel, busy); end
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 4) mask = 4'b0001;  // mid-scan mask change must be ignored
      checks++;
      if (sel !== ((k >= 12) ? 2'd3 : 2'(k / 3))) begin
        errors++; $display("FAIL scan_sel edge %0d: got %0d expected %0d", k, sel, (k >= 12) ? 3 : k / 3);
      end
      checks++;
      if (valid !== (k == 12) || busy !== (k < 12)) begin
        errors++; $display("FAIL scan_flags edge %0d: valid %0b busy %0b expected %0b %0b", k, valid, busy, k == 12, k < 12);
      end
    end
    checks++; if (frame !== 4'b1010) begin errors++; $display("FAIL scan_frame: got %b expected 1010", frame); end
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (valid !== 1'b1 || frame !== 4'b1010 || sel !== 2'd3 || busy !== 1'b0) begin
        errors++; $display("FAIL bp_hold %0d: valid %0b frame %b sel %0d busy %0b expected 1 1010 3 0", k, valid, frame, sel, busy);
      end
    end
    ready = 1'b1;
    step();
    ready = 1'b0;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL bp_accept: valid %0b expected 0", valid); end
    step();
    checks++; if (valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_idle: valid %0b busy %0b expected 0 0", valid, busy); end
  endtask

  task automatic test_reset_mid_scan();
    mask = 4'b1111; start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    checks++; if (sel !== 2'd1 || busy !== 1'b1) begin errors++; $display("FAIL rst_pre: sel %0d busy %0b expected 1 1", sel, busy); end
    rst = 1'b1;
    #1;
    checks++;
    if (sel !== 2'd0 || busy !== 1'b0 || frame !== 4'h0 || valid !== 1'b0) begin
      errors++; $display("FAIL rst_async: sel %0d busy %0b frame %h valid %0b expected all 0", sel, busy, frame, valid);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
    checks++; if (busy !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL rst_idle: busy %0b valid %0b expected 0 0", busy, valid); end
  endtask

  task automatic test_mask_skip();
    int   cycles;
    logic [3:0] visited;
    d = 4'b1111; mask = 4'b0101; ready = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    visited = 4'b0001 << sel;
    cycles  = 0;
    while (!valid && cycles < 40) begin
      step();
      cycles++;
      if (busy) visited |= 4'b0001 << sel;
    end
    checks++; if (cycles !== 6) begin errors++; $display("FAIL skip_latency: got %0d expected 6", cycles); end
    checks++; if (visited !== 4'b0101) begin errors++; $display("FAIL skip_visited: got %b expected 0101", visited); end
    checks++; if (frame !== 4'b0101) begin errors++; $display("FAIL skip_frame: got %b expected 0101", frame); end
    ready = 1'b1; step(); ready = 1'b0;
    mask = 4'b0000; start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (valid !== 1'b1 || frame !== 4'h0 || busy !== 1'b0) begin
      errors++; $display("FAIL empty_mask: valid %0b frame %h busy %0b expected 1 0 0", valid, frame, busy);
    end
    ready = 1'b1; step(); ready = 1'b0;
  endtask

  task automatic test_continuous();
    int p;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    step();
    cont = 1'b1; ready = 1'b1; mask = 4'b1111; d = 4'b0110; start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (sel0 !== 2'd0 || busy0 !== 1'b1) begin errors++; $display("FAIL cont_start: sel %0d busy %0b expected 0 1", sel0, busy0); end
    for (int k = 1; k <= 20; k++) begin
      start = (k == 7 || k == 8);  // start during a scan must be ignored
      step();
      p = k % 5;
      checks++;
      if (sel0 !== ((p == 4) ? 2'd3 : 2'(p)) || valid0 !== (p == 4) || busy0 !== (p != 4)) begin
        errors++; $display("FAIL cont edge %0d: sel %0d valid %0b busy %0b expected %0d %0b %0b",
                           k, sel0, valid0, busy0, (p == 4) ? 3 : p, p == 4, p != 4);
      end
      if (p == 4) begin
        checks++; if (frame0 !== 4'b0110) begin errors++; $display("FAIL cont_frame edge %0d: got %b expected 0110", k, frame0); end
      end
    end
    start = 1'b0; cont = 1'b0;
    repeat (20) step();
    ready = 1'b0;
    checks++; if (busy0 !== 1'b0 || valid0 !== 1'b0) begin errors++; $display("FAIL cont_stop: busy %0b valid %0b expected 0 0", busy0, valid0); end
  endtask

  task automatic test_clear();
    d = 4'b0100; mask = 4'b1110; ready = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    checks++; if (sel !== 2'd2 || busy !== 1'b1) begin errors++; $display("FAIL clr_pre: sel %0d busy %0b expected 2 1", sel, busy); end
    clear = 1'b1;
    step();
    clear = 1'b0;
    checks++; if (busy !== 1'b0 || valid !== 1'b0 || sel !== 2'd2) begin errors++; $display("FAIL clr_settle: busy %0b valid %0b sel %0d expected 0 0 2", busy, valid, sel); end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clr_idle: busy %0b expected 0", busy); end
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (sel !== 2'd1 || busy !== 1'b1) begin errors++; $display("FAIL clr_rescan: sel %0d busy %0b expected 1 1", sel, busy); end
    repeat (9) step();
    checks++; if (valid !== 1'b1 || frame !== 4'b0100) begin errors++; $display("FAIL clr_frame: valid %0b frame %b expected 1 0100", valid, frame); end
    clear = 1'b1;
    step();
    clear = 1'b0;
    checks++; if (valid !== 1'b0 || busy !== 1'b0 || frame !== 4'b0100) begin errors++; $display("FAIL clr_present: valid %0b busy %0b frame %b expected 0 0 0100", valid, busy, frame); end
    step();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL clr_hold: valid %0b expected 0", valid); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; cont = 1'b0; clear = 1'b0; ready = 1'b0;
    mask = 4'h0; d = 4'h0;
    #2;
    test_reset();
    test_scan();
    test_backpressure();
    test_reset_mid_scan();
    test_mask_skip();
    test_continuous();
    test_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
